// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: takes the ALU effective address plus store data and
// funct3, runs a req/gnt/rvalid handshake with data memory, and returns aligned,
// extended load data with a one-cycle done (and err) pulse to release the stall.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state;
  logic        wr_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  cnt;

  logic        bad_f3;
  logic        misal;
  logic        fault;
  logic        complete;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_data;
  logic [3:0]  be_lane;
  logic [31:0] wdata_lane;

  // Classify the incoming op: illegal width code or misaligned address.
  always_comb begin
    bad_f3 = 1'b0;
    misal  = 1'b0;
    case (funct3)
      3'b000: ;
      3'b001: misal = addr[0];
      3'b010: misal = (addr[1:0] != 2'b00);
      3'b100: bad_f3 = op_write;
      3'b101: begin
        bad_f3 = op_write;
        misal  = addr[0];
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign fault = bad_f3 | misal;

  assign complete = ((state == S_REQ) && mem_gnt && (wr_q || mem_rvalid)) ||
                    ((state == S_WAIT) && mem_rvalid);

  // Pick the addressed lane out of the read word and sign/zero-extend it.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   byte_sel = mem_rdata[7:0];
      2'b01:   byte_sel = mem_rdata[15:8];
      2'b10:   byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   ld_data = {{24{byte_sel[7] & ~f3_q[2]}}, byte_sel};
      2'b01:   ld_data = {{16{half_sel[15] & ~f3_q[2]}}, half_sel};
      default: ld_data = mem_rdata;
    endcase
  end

  // Byte enables and lane-replicated store data for the latched op.
  always_comb begin
    be_lane    = '0;
    wdata_lane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be_lane    = 4'b0001 << addr_q[1:0];
        wdata_lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_lane    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      2'b10:   be_lane = '1;
      default: be_lane = '0;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign mem_req   = (state == S_REQ);
  assign mem_we    = mem_req & wr_q;
  assign mem_be    = mem_req ? be_lane : '0;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_lane;

  // Handshake FSM, timeout counter, op latch and load result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      wr_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt     <= '0;
      rdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            wr_q    <= op_write;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= '0;
            if (fault) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= S_REQ;
            end
          end
        end
        S_REQ, S_WAIT: begin
          // A completion on the final allowed cycle wins over the timeout.
          if (complete) begin
            if (!wr_q) rdata <= ld_data;
            state <= S_DONE;
            done  <= 1'b1;
          end else if (cnt + 8'd1 == TMO) begin
            state <= S_DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
            if (state == S_REQ && mem_gnt) state <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed scenarios plus randomized ops
// against a behavioural model of lanes, extension, faults, latency and timeout.
module tb_lsu_mem_stage;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_rdata = '0;

  lsu_mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_write(op_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .err(err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_fault(bit w, logic [2:0] f, logic [31:0] a);
    case (f)
      3'd0:    return 1'b0;
      3'd1:    return a[0];
      3'd2:    return a[1:0] != 2'b00;
      3'd4:    return w;
      3'd5:    return w || a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic int size_of(logic [2:0] f);
    return 1 << int'(f[1:0]);
  endfunction

  function automatic int offset_of(logic [2:0] f, logic [31:0] a);
    int sz = size_of(f);
    return (int'(a[1:0]) / sz) * sz;
  endfunction

  function automatic logic [3:0] model_be(logic [2:0] f, logic [31:0] a);
    logic [3:0] be = '0;
    int off = offset_of(f, a);
    for (int i = 0; i < 4; i++)
      be[i] = (i >= off) && (i < off + size_of(f));
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(logic [2:0] f, logic [31:0] wd);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = wd[8*(i % size_of(f)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(logic [2:0] f, logic [31:0] a, logic [31:0] word);
    longint unsigned v    = longint'(word) >> (8 * offset_of(f, a));
    longint unsigned span = longint'(1) << (8 * size_of(f));
    v = v % span;
    if (!f[2] && size_of(f) < 4 && v >= span / 2)
      v = v + 64'h1_0000_0000 - span;
    return v[31:0];
  endfunction

  // One complete op: drive request, act as memory, check every cycle until done.
  task automatic do_op(input bit w, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] wd, input int gd, input int rd,
                       input bit no_rv, input logic [31:0] rword, input bit hold);
    bit fault = model_fault(w, f, a);
    int need;
    int done_c;
    int req_end;
    bit xerr;
    bit xreq;
    need = (w || rd == 0) ? gd + 1 : gd + 1 + rd;
    if (!w && no_rv) need = 1000;
    if (fault) begin
      done_c = 1; xerr = 1'b1; req_end = 0;
    end else if (need <= T) begin
      done_c = need + 1; xerr = 1'b0; req_end = (gd + 1 < T) ? gd + 1 : T;
    end else begin
      done_c = T + 1; xerr = 1'b1; req_end = (gd + 1 < T) ? gd + 1 : T;
    end
    @(negedge clk);
    op_valid = 1'b1; op_write = w; funct3 = f; addr = a; wdata = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      xreq = !fault && c <= req_end;
      check("busy", busy, 1);
      check("done", done, c == done_c);
      check("mem_req", mem_req, xreq);
      if (xreq) begin
        check("mem_we", mem_we, w);
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
        check("mem_be", mem_be, model_be(f, a));
        if (w) check("mem_wdata", mem_wdata, model_wdata(f, wd));
      end
      if (c == done_c) begin
        check("err", err, xerr);
        if (!w && !xerr) exp_rdata = model_load(f, a, rword);
        check("rdata", rdata, exp_rdata);
        if (!hold) op_valid = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end else begin
        mem_gnt    = (c == gd + 1);
        mem_rvalid = !w && !no_rv && (c == gd + 1 + rd);
        mem_rdata  = mem_rvalid ? rword : $urandom;
      end
    end
    @(negedge clk);
    op_valid = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("rdata_hold", rdata, exp_rdata);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_be", mem_be, 0);
    check("rst_rdata", rdata, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    rst = 1'b0;

    do_op(1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 0);
    do_op(0, 3'b000, 32'h0000_2003, 32'h0, 0, 1, 0, 32'h80FF_7F01, 0);
    do_op(0, 3'b100, 32'h0000_2003, 32'h0, 0, 1, 0, 32'h80FF_7F01, 1);
    do_op(0, 3'b001, 32'h0000_2002, 32'h0, 0, 1, 0, 32'h80FF_7F01, 0);
    do_op(1, 3'b001, 32'h0000_3001, 32'h0, 0, 0, 0, 32'h0, 0);
    do_op(1, 3'b011, 32'h0000_3001, 32'h0, 0, 0, 0, 32'h0, 0);
    do_op(1, 3'b000, 32'h0000_4002, 32'h1234_56AB, 5, 0, 0, 32'h0, 0);
    do_op(0, 3'b010, 32'h0000_5000, 32'h0, 0, 0, 1, 32'h0, 0);

    // Reset while waiting for read data; the late response must be dropped.
    @(negedge clk);
    op_valid = 1'b1; op_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0100;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("wait_req", mem_req, 0);
    check("wait_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; op_valid = 1'b0;
    exp_rdata = '0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_done", done, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_done", done, 0);
    check("late_busy", busy, 0);
    check("late_rdata", rdata, exp_rdata);
    do_op(0, 3'b010, 32'h0000_0010, 32'h0, 0, 1, 0, 32'h0000_0042, 0);

    for (int n = 0; n < 300; n++) begin
      int gd;
      gd = ($urandom % 10 < 8) ? int'($urandom % 4) : int'($urandom_range(5, 9));
      do_op(1'($urandom % 2), 3'($urandom % 8), $urandom, $urandom, gd,
            int'($urandom % 4), ($urandom % 12) == 0, $urandom, 1'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
